// File: rtl/ifetch_unit.sv
// Instruction fetch front end: sequential PC generation, credit-limited bus requests,
// an in-order instruction FIFO toward decode, and redirect handling that drops stale responses.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h8000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        o_req_valid,
  input  logic        i_req_ready,
  output logic [31:0] o_req_addr,
  input  logic        i_rsp_valid,
  output logic        o_rsp_ready,
  input  logic [31:0] i_rsp_data,
  input  logic        i_rsp_err,
  output logic        o_ir_valid,
  input  logic        i_ir_ready,
  output logic [31:0] o_ir,
  output logic [31:0] o_pc,
  output logic        o_ir_err,
  input  logic        i_flush,
  input  logic [31:0] i_flush_pc
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = CW + 2;

  logic [31:0]   r_pc;
  logic [31:0]   r_rsp_pc;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] r_drop_cnt;
  logic [CW-1:0] r_count;
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [31:0]   r_fifo_ir  [FIFO_DEPTH];
  logic [31:0]   r_fifo_pc  [FIFO_DEPTH];
  logic          r_fifo_err [FIFO_DEPTH];

  logic [SW-1:0] w_credit_sum;
  logic          w_req_fire;
  logic          w_rsp_drop;
  logic          w_push;
  logic          w_pop;

  // Every in-flight request (live or doomed) and every buffered entry holds one credit,
  // so a returning response always finds FIFO space.
  assign w_credit_sum = SW'(r_outstanding) + SW'(r_drop_cnt) + SW'(r_count);
  assign o_req_valid  = rst_n & ~i_flush & (w_credit_sum < SW'(FIFO_DEPTH));
  assign o_req_addr   = r_pc;
  assign o_rsp_ready  = 1'b1;

  assign w_req_fire = o_req_valid & i_req_ready;
  assign w_rsp_drop = i_rsp_valid & (r_drop_cnt != '0);
  assign w_push     = i_rsp_valid & (r_drop_cnt == '0);
  assign w_pop      = o_ir_valid & i_ir_ready;

  assign o_ir_valid = (r_count != '0);
  assign o_ir       = r_fifo_ir[r_rptr];
  assign o_pc       = r_fifo_pc[r_rptr];
  assign o_ir_err   = r_fifo_err[r_rptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc          <= RESET_PC;
      r_rsp_pc      <= RESET_PC;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
      r_count       <= '0;
      r_wptr        <= '0;
      r_rptr        <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_fifo_ir[i]  <= '0;
        r_fifo_pc[i]  <= '0;
        r_fifo_err[i] <= 1'b0;
      end
    end else if (i_flush) begin
      // A response arriving now retires one in-flight request; the rest become drops.
      r_pc          <= {i_flush_pc[31:2], 2'b00};
      r_rsp_pc      <= {i_flush_pc[31:2], 2'b00};
      r_drop_cnt    <= r_drop_cnt + r_outstanding - CW'(i_rsp_valid);
      r_outstanding <= '0;
      r_count       <= '0;
      r_wptr        <= '0;
      r_rptr        <= '0;
    end else begin
      if (w_req_fire) begin
        r_pc <= r_pc + 32'd4;
      end
      if (w_rsp_drop) begin
        r_drop_cnt <= r_drop_cnt - CW'(1);
      end
      r_outstanding <= r_outstanding + CW'(w_req_fire) - CW'(w_push);
      if (w_push) begin
        r_fifo_ir[r_wptr]  <= i_rsp_data;
        r_fifo_pc[r_wptr]  <= r_rsp_pc;
        r_fifo_err[r_wptr] <= i_rsp_err;
        r_wptr             <= r_wptr + AW'(1);
        r_rsp_pc           <= r_rsp_pc + 32'd4;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  a_credit : assert property (@(posedge clk) disable iff (!rst_n)
    w_credit_sum <= SW'(FIFO_DEPTH));
  a_align : assert property (@(posedge clk) disable iff (!rst_n)
    o_req_addr[1:0] == 2'b00);

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: directed vector table, a mid-operation reset sequence,
// and a randomized run against a queue-based model of requests and buffered instructions.
module tb_ifetch_unit;

  localparam logic [31:0] B     = 32'h8000_0000;
  localparam logic [31:0] Z     = 32'h0;
  localparam int          DEPTH = 2;
  localparam bit          Y     = 1'b1;
  localparam bit          N     = 1'b0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_req_ready = 1'b0;
  logic        i_rsp_valid = 1'b0;
  logic [31:0] i_rsp_data = '0;
  logic        i_rsp_err = 1'b0;
  logic        i_ir_ready = 1'b0;
  logic        i_flush = 1'b0;
  logic [31:0] i_flush_pc = '0;
  logic        o_req_valid, o_rsp_ready, o_ir_valid, o_ir_err;
  logic [31:0] o_req_addr, o_ir, o_pc;

  always #5 clk = ~clk;

  ifetch_unit #(.RESET_PC(B), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .o_req_valid(o_req_valid), .i_req_ready(i_req_ready), .o_req_addr(o_req_addr),
    .i_rsp_valid(i_rsp_valid), .o_rsp_ready(o_rsp_ready), .i_rsp_data(i_rsp_data),
    .i_rsp_err(i_rsp_err),
    .o_ir_valid(o_ir_valid), .i_ir_ready(i_ir_ready), .o_ir(o_ir), .o_pc(o_pc),
    .o_ir_err(o_ir_err), .i_flush(i_flush), .i_flush_pc(i_flush_pc)
  );

  int total = 0;
  int bad = 0;

  typedef struct {
    bit rst; bit fl; logic [31:0] fpc; bit rq; bit rv; logic [31:0] ra; bit re; bit ir;
    bit e_rv; logic [31:0] e_ra; bit e_iv; logic [31:0] e_pc; bit e_err;
  } vec_t;
  vec_t tbl[$];

  // Model: every accepted request in order (live until a redirect kills it), and the decode queue.
  typedef struct { logic [31:0] addr; bit live; } bus_t;
  typedef struct { logic [31:0] ir; logic [31:0] pc; bit err; } ent_t;
  bus_t        bq[$];
  ent_t        fq[$];
  logic [31:0] mpc;

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  task automatic chk1(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0b want %0b", nm, act, exp);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(input bit fl, input logic [31:0] fpc, input bit rq, input bit rv,
                       input logic [31:0] ra, input bit re, input bit ir);
    i_flush     = fl;
    i_flush_pc  = fpc;
    i_req_ready = rq;
    i_rsp_valid = rv;
    i_rsp_data  = rv ? data_of(ra) : 32'h0;
    i_rsp_err   = rv & re;
    i_ir_ready  = ir;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive(N, Z, N, N, Z, N, N);
    #1;
    chk1("rst req_valid", o_req_valid, 1'b0);
    chk1("rst ir_valid", o_ir_valid, 1'b0);
    chk32("rst ir", o_ir, 32'h0);
    chk32("rst pc", o_pc, 32'h0);
    chk1("rst ir_err", o_ir_err, 1'b0);
    chk1("rst rsp_ready", o_rsp_ready, 1'b1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bq.delete();
    fq.delete();
    mpc = B;
  endtask

  initial begin
    // Basic flow with a faulting fetch at B+4.
    tbl.push_back('{Y,N,Z,Y,N,Z,N,Y,        Y,B,N,Z,N});
    tbl.push_back('{N,N,Z,Y,Y,B,N,Y,        Y,B+4,N,Z,N});
    tbl.push_back('{N,N,Z,Y,Y,B+4,Y,Y,      N,Z,Y,B,N});
    tbl.push_back('{N,N,Z,Y,N,Z,N,Y,        Y,B+8,Y,B+4,Y});
    tbl.push_back('{N,N,Z,Y,Y,B+8,N,Y,      Y,B+12,N,Z,N});
    tbl.push_back('{N,N,Z,Y,Y,B+12,N,Y,     N,Z,Y,B+8,N});
    tbl.push_back('{N,N,Z,Y,N,Z,N,Y,        Y,B+16,Y,B+12,N});
    // Decode stalled: two requests fill the FIFO, then drain and resume.
    tbl.push_back('{Y,N,Z,Y,N,Z,N,N,        Y,B,N,Z,N});
    tbl.push_back('{N,N,Z,Y,Y,B,N,N,        Y,B+4,N,Z,N});
    tbl.push_back('{N,N,Z,Y,Y,B+4,N,N,      N,Z,Y,B,N});
    tbl.push_back('{N,N,Z,Y,N,Z,N,Y,        N,Z,Y,B,N});
    tbl.push_back('{N,N,Z,Y,N,Z,N,Y,        Y,B+8,Y,B+4,N});
    tbl.push_back('{N,N,Z,Y,Y,B+8,N,Y,      Y,B+12,N,Z,N});
    tbl.push_back('{N,N,Z,Y,Y,B+12,N,Y,     N,Z,Y,B+8,N});
    tbl.push_back('{N,N,Z,Y,N,Z,N,Y,        Y,B+16,Y,B+12,N});
    // Flush with two requests in flight: both responses dropped, refetch at B+100.
    tbl.push_back('{Y,N,Z,Y,N,Z,N,Y,        Y,B,N,Z,N});
    tbl.push_back('{N,N,Z,Y,N,Z,N,Y,        Y,B+4,N,Z,N});
    tbl.push_back('{N,Y,B+32'h103,Y,N,Z,N,Y, N,Z,N,Z,N});
    tbl.push_back('{N,N,Z,Y,Y,B,N,Y,        N,Z,N,Z,N});
    tbl.push_back('{N,N,Z,Y,Y,B+4,N,Y,      Y,B+32'h100,N,Z,N});
    tbl.push_back('{N,N,Z,Y,Y,B+32'h100,N,Y, Y,B+32'h104,N,Z,N});
    tbl.push_back('{N,N,Z,Y,Y,B+32'h104,N,Y, N,Z,Y,B+32'h100,N});
    tbl.push_back('{N,N,Z,Y,N,Z,N,Y,        Y,B+32'h108,Y,B+32'h104,N});
    // Flush coinciding with a response and a decode pop.
    tbl.push_back('{Y,N,Z,Y,N,Z,N,Y,        Y,B,N,Z,N});
    tbl.push_back('{N,N,Z,Y,Y,B,N,Y,        Y,B+4,N,Z,N});
    tbl.push_back('{N,Y,B+32'h200,Y,Y,B+4,N,Y, N,Z,Y,B,N});
    tbl.push_back('{N,N,Z,Y,N,Z,N,Y,        Y,B+32'h200,N,Z,N});
    tbl.push_back('{N,N,Z,Y,Y,B+32'h200,N,Y, Y,B+32'h204,N,Z,N});
    tbl.push_back('{N,N,Z,Y,Y,B+32'h204,N,Y, N,Z,Y,B+32'h200,N});
    tbl.push_back('{N,N,Z,Y,N,Z,N,Y,        Y,B+32'h208,Y,B+32'h204,N});
    // Address wrap at the top of the address space, with a misaligned redirect target.
    tbl.push_back('{Y,Y,32'hFFFF_FFFE,Y,N,Z,N,Y, N,Z,N,Z,N});
    tbl.push_back('{N,N,Z,Y,N,Z,N,Y,        Y,32'hFFFF_FFFC,N,Z,N});
    tbl.push_back('{N,N,Z,Y,Y,32'hFFFF_FFFC,N,Y, Y,32'h0,N,Z,N});
    tbl.push_back('{N,N,Z,Y,Y,32'h0,N,Y,    N,Z,Y,32'hFFFF_FFFC,N});
    tbl.push_back('{N,N,Z,Y,N,Z,N,Y,        Y,32'h4,Y,32'h0,N});

    foreach (tbl[k]) begin
      if (tbl[k].rst) do_reset();
      @(negedge clk);
      drive(tbl[k].fl, tbl[k].fpc, tbl[k].rq, tbl[k].rv, tbl[k].ra, tbl[k].re, tbl[k].ir);
      #1;
      chk1($sformatf("v%0d req_valid", k), o_req_valid, tbl[k].e_rv);
      if (tbl[k].e_rv) chk32($sformatf("v%0d req_addr", k), o_req_addr, tbl[k].e_ra);
      chk1($sformatf("v%0d ir_valid", k), o_ir_valid, tbl[k].e_iv);
      if (tbl[k].e_iv) begin
        chk32($sformatf("v%0d pc", k), o_pc, tbl[k].e_pc);
        chk32($sformatf("v%0d ir", k), o_ir, data_of(tbl[k].e_pc));
        chk1($sformatf("v%0d ir_err", k), o_ir_err, tbl[k].e_err);
      end
    end

    // Reset asserted between clock edges with a full FIFO clears everything immediately.
    do_reset();
    @(negedge clk); drive(N, Z, Y, N, Z, N, N);
    @(negedge clk); drive(N, Z, Y, Y, B, N, N);
    @(negedge clk); drive(N, Z, Y, Y, B + 4, N, N);
    @(negedge clk); drive(N, Z, Y, N, Z, N, N);
    #1;
    chk1("midrst pre ir_valid", o_ir_valid, 1'b1);
    chk32("midrst pre pc", o_pc, B);
    #3;
    rst_n = 1'b0;
    #1;
    chk1("midrst ir_valid", o_ir_valid, 1'b0);
    chk32("midrst pc", o_pc, 32'h0);
    chk32("midrst ir", o_ir, 32'h0);
    chk1("midrst req_valid", o_req_valid, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk); drive(N, Z, Y, N, Z, N, Y);
    #1;
    chk1("midrst post req_valid", o_req_valid, 1'b1);
    chk32("midrst post req_addr", o_req_addr, B);
    chk1("midrst post ir_valid", o_ir_valid, 1'b0);

    // Randomized run against the queue model.
    do_reset();
    for (int cyc = 0; cyc < 4000; cyc++) begin
      bit   m_req_v, m_ir_v, rv, live;
      bus_t e;
      @(negedge clk);
      rv = (bq.size() > 0) && ($urandom_range(0, 2) != 0);
      drive($urandom_range(0, 15) == 0, $urandom, $urandom_range(0, 3) != 0, rv,
            rv ? bq[0].addr : Z, $urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0);
      #1;
      m_req_v = !i_flush && (bq.size() + fq.size() < DEPTH);
      m_ir_v  = fq.size() != 0;
      chk1($sformatf("r%0d req_valid", cyc), o_req_valid, m_req_v);
      if (m_req_v) chk32($sformatf("r%0d req_addr", cyc), o_req_addr, mpc);
      chk1($sformatf("r%0d ir_valid", cyc), o_ir_valid, m_ir_v);
      if (m_ir_v) begin
        chk32($sformatf("r%0d pc", cyc), o_pc, fq[0].pc);
        chk32($sformatf("r%0d ir", cyc), o_ir, fq[0].ir);
        chk1($sformatf("r%0d ir_err", cyc), o_ir_err, fq[0].err);
      end
      live = 1'b0;
      if (rv) begin
        e = bq.pop_front();
        live = e.live;
      end
      if (i_flush) begin
        fq.delete();
        foreach (bq[i]) bq[i].live = 1'b0;
        mpc = {i_flush_pc[31:2], 2'b00};
      end else begin
        if (m_ir_v && i_ir_ready) void'(fq.pop_front());
        if (live) fq.push_back('{data_of(e.addr), e.addr, i_rsp_err});
        if (m_req_v && i_req_ready) begin
          bq.push_back('{mpc, 1'b1});
          mpc = mpc + 32'd4;
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
